mem_stage: RTL
==============

# mem_stage

Memory-access stage of the five-stage MIPS pipeline. It sits between the EX/MEM register and the MEM/WB register. It holds the word-addressed data memory and performs sb/sh/sw stores on the clock edge. It returns the extended lb/lbu/lh/lhu/lw load value combinationally, so the MEM/WB register captures it as M_DMRD in the same cycle.

## Interface
Parameters:
- DEPTH, 3072: number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH-1.
- AW, 12: word-index width; must satisfy 2^AW >= DEPTH.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; sampled only on posedge clk.
- M_PC  input  32  PC of the instruction in MEM; used only for the write log.
- M_Instr  input  32  instruction in MEM; opcode [31:26] selects the access.
- M_ALUAns  input  32  effective byte address.
- M_WD  input  32  store data, already forwarded (rt value).
- M_DMRD  output  32  load result, extended to 32 bits; 0 for non-loads.
- M_DMWE  output  1  high when a store to an in-range address will commit this cycle.

## Operation
- Opcode decode:
  - Loads: lw 100011, lb 100000, lbu 100100, lh 100001, lhu 100101.
  - Stores: sw 101011, sb 101000, sh 101001.
  - Any other opcode is a no-op: no write, M_DMRD = 0.
- Word index = M_ALUAns[AW+1:2]. Byte lane = M_ALUAns[1:0]. Half lane = M_ALUAns[1].
- Alignment: low address bits are ignored for lw/sw, and bit 0 is ignored for lh/lhu/sh. No exception is raised.
- Range check: address >= 4*DEPTH is out of range.
  - Out-of-range store: no write, no log, M_DMWE = 0.
  - Out-of-range load: M_DMRD = 0.
- Loads (combinational from current memory contents and address):
  - lw: full word.
  - lh/lhu: half [15:0] if lane 0, [31:16] if lane 1; sign- or zero-extended.
  - lb/lbu: byte lane k = bits [8k+7:8k]; sign- or zero-extended.
- Stores (on posedge clk when not in reset):
  - Merged word = old word with only the addressed lane replaced.
  - sb writes M_WD[7:0] into lane k; sh writes M_WD[15:0] into the selected half; sw writes the whole word.
- Write log on every committed store, in exactly this format: `$display("@%h: *%h <= %h", M_PC, {M_ALUAns[31:2],2'b00}, merged_word)`. Addresses and data are 8-digit hex.
- Reset: on a posedge with reset=1, every word is cleared to 0.

## Timing
- Load latency: zero cycles (combinational). M_DMRD is valid before the same posedge that loads the MEM/WB register.
- Store latency: one edge. Data is visible to a load presented in the following cycle.
- Same-cycle store then load to the same word: the load presented in that cycle sees the old contents. The next cycle sees the new contents.
- reset and store asserted on the same edge: reset wins. Memory is cleared, no write occurs, no log line is printed.
- Reset mid-stream: contents read 0 from the cycle after the reset edge. There is no other state.
- Output reset values:
  - M_DMRD is a function of memory contents and inputs, so it equals 0 after reset for any load.
  - M_DMWE is purely combinational from the decode and range check. It does not depend on reset.
- At the cycle-0 start of simulation, memory initialises to 0 without waiting for reset.
- Pipeline control: stall and flush are handled by the upstream/downstream registers. A bubble (M_Instr = 0) is a no-op here.

## Test plan
- Reset, then sw 0x12345678 to addr 0x10, then lw from 0x10.
  - Required: M_DMRD = 0x12345678.
  - Required log: `@<pc>: *00000010 <= 12345678`.
- After the above, sb 0x000000AB to addr 0x12, then lb and lbu from 0x12.
  - Required: word = 0x12AB5678; lb → 0xFFFFFFAB; lbu → 0x000000AB.
- sh 0x0000BEEF to addr 0x22 on a zeroed word, then lh and lhu from 0x22, then lw from 0x20.
  - Required: lh → 0xFFFFBEEF; lhu → 0x0000BEEF; lw → 0xBEEF0000.
- sw to addr 0x3000 with DEPTH=3072, then lw from 0x3000.
  - Required: M_DMWE = 0, no log line, M_DMRD = 0, and memory unchanged (spot-check word 0).
- Assert reset on the same edge as sw 0xFFFFFFFF to 0x10.
  - Required: no log line; lw from 0x10 returns 0 on the next cycle.
- Store and load to the same word in consecutive cycles.
  - Required: the load returns the new value.
  - Separately, a non-memory opcode (addu) with any address: M_DMRD = 0, M_DMWE = 0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: word-addressed data memory with combinational extended
// loads and byte/half/word merged stores committed on the rising clock edge.
module mem_stage #(
    parameter int DEPTH = 3072,
    parameter int AW    = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] M_PC,
    input  logic [31:0] M_Instr,
    input  logic [31:0] M_ALUAns,
    input  logic [31:0] M_WD,
    output logic [31:0] M_DMRD,
    output logic        M_DMWE
);

    localparam logic [5:0]  OP_LW  = 6'b100011;
    localparam logic [5:0]  OP_LB  = 6'b100000;
    localparam logic [5:0]  OP_LBU = 6'b100100;
    localparam logic [5:0]  OP_LH  = 6'b100001;
    localparam logic [5:0]  OP_LHU = 6'b100101;
    localparam logic [5:0]  OP_SW  = 6'b101011;
    localparam logic [5:0]  OP_SB  = 6'b101000;
    localparam logic [5:0]  OP_SH  = 6'b101001;
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

    // Memory powers up cleared so loads before the first reset read zero.
    logic [31:0] mem_r [DEPTH] = '{default: 32'h0000_0000};

    logic [5:0]    op_s;
    logic          in_range_s;
    logic [AW-1:0] idx_s;
    logic [1:0]    lane_s;
    logic [31:0]   word_s;
    logic [7:0]    byte_s;
    logic [15:0]   half_s;
    logic [31:0]   merged_s;

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

    // Address decode and lane extraction from the current word.
    always_comb begin
        op_s       = M_Instr[31:26];
        in_range_s = (M_ALUAns < ADDR_LIMIT);
        idx_s      = M_ALUAns[AW+1:2];
        lane_s     = M_ALUAns[1:0];
        word_s     = in_range_s ? mem_r[idx_s] : 32'h0000_0000;
        half_s     = M_ALUAns[1] ? word_s[31:16] : word_s[15:0];
        case (lane_s)
            2'd0:    byte_s = word_s[7:0];
            2'd1:    byte_s = word_s[15:8];
            2'd2:    byte_s = word_s[23:16];
            2'd3:    byte_s = word_s[31:24];
            default: byte_s = 8'h00;
        endcase
    end

    // Load result selection; out-of-range reads already see a zero word.
    always_comb begin
        case (op_s)
            OP_LW:   M_DMRD = word_s;
            OP_LB:   M_DMRD = ext8(byte_s, 1'b1);
            OP_LBU:  M_DMRD = ext8(byte_s, 1'b0);
            OP_LH:   M_DMRD = ext16(half_s, 1'b1);
            OP_LHU:  M_DMRD = ext16(half_s, 1'b0);
            default: M_DMRD = 32'h0000_0000;
        endcase
    end

    // Store enable and merge of the addressed lane into the old word.
    always_comb begin
        merged_s = word_s;
        M_DMWE   = 1'b0;
        case (op_s)
            OP_SW: begin
                M_DMWE   = in_range_s;
                merged_s = M_WD;
            end
            OP_SH: begin
                M_DMWE = in_range_s;
                if (M_ALUAns[1]) begin
                    merged_s[31:16] = M_WD[15:0];
                end else begin
                    merged_s[15:0] = M_WD[15:0];
                end
            end
            OP_SB: begin
                M_DMWE = in_range_s;
                case (lane_s)
                    2'd0:    merged_s[7:0]   = M_WD[7:0];
                    2'd1:    merged_s[15:8]  = M_WD[7:0];
                    2'd2:    merged_s[23:16] = M_WD[7:0];
                    2'd3:    merged_s[31:24] = M_WD[7:0];
                    default: merged_s        = word_s;
                endcase
            end
            default: begin
                M_DMWE   = 1'b0;
                merged_s = word_s;
            end
        endcase
    end

    // Reset clears every word and takes priority over a same-edge store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (M_DMWE) begin
            mem_r[idx_s] <= merged_s;
            $display("@%h: *%h <= %h", M_PC, {M_ALUAns[31:2], 2'b00}, merged_s);
        end
    end

endmodule
